// File: rtl/alu16_structural_if.sv
//------------------------------------------------------------------------------
// Module : alu16_structural_if
// Brief  : Operand/opcode bus and registered result/flags of the 16-bit ALU.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu16_structural_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] m;
  logic [2:0]       opc;
  logic             c;
  logic [WIDTH-1:0] f;
  logic             zer;
  logic             neg;

  modport master (output n, m, opc, c, input f, zer, neg);
  modport slave  (input n, m, opc, c, output f, zer, neg);
endinterface

`default_nettype wire

// File: rtl/alu16_structural.sv
//------------------------------------------------------------------------------
// Module : alu16_structural
// Brief  : Signed ALU execute stage: ripple add/sub, logic, shift, registered flags.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu16_structural #(
  parameter int WIDTH = 16
) (
  input  wire                clk,
  input  wire                rst,
  alu16_structural_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  logic             is_sub;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] r;

  // One adder chain serves ADD and SUB; SUB inverts B and forces carry-in high.
  assign is_sub   = (bus.opc == OP_SUB);
  assign b_in     = is_sub ? ~bus.m : bus.m;
  assign carry[0] = is_sub | ((bus.opc == OP_ADD) & bus.c);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i] = bus.n[i] ^ b_in[i] ^ carry[i];
      if (i < WIDTH-1) begin : g_carry
        assign carry[i+1] = (bus.n[i] & b_in[i]) | (carry[i] & (bus.n[i] ^ b_in[i]));
      end
    end
  endgenerate

  always_comb begin
    logic_res = '0;
    case (bus.opc)
      OP_AND:  logic_res = bus.n & bus.m;
      OP_OR:   logic_res = bus.n | bus.m;
      OP_NOT:  logic_res = ~bus.n;
      OP_XOR:  logic_res = bus.n ^ bus.m;
      default: logic_res = '0;
    endcase
  end

  assign shift_res = (bus.opc == OP_SHL) ? {bus.n[WIDTH-2:0], bus.c}
                                         : {bus.n[WIDTH-1], bus.n[WIDTH-1:1]};

  always_comb begin
    r = '0;
    case (bus.opc)
      OP_ADD, OP_SUB:                 r = sum;
      OP_AND, OP_OR, OP_NOT, OP_XOR:  r = logic_res;
      OP_SHL, OP_ASR:                 r = shift_res;
      default:                        r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.f   <= '0;
      bus.zer <= 1'b1;
      bus.neg <= 1'b0;
    end else begin
      bus.f   <= r;
      bus.zer <= (r == '0);
      bus.neg <= r[WIDTH-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu16_structural.sv
//------------------------------------------------------------------------------
// Module : tb_alu16_structural
// Brief  : Directed and reference-model checks of alu16_structural.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu16_structural;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  alu16_structural_if #(.WIDTH(16)) bus ();

  alu16_structural #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got f=%h zer=%b neg=%b, expected f=%h zer=%b neg=%b",
               tag, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic ci);
    case (op)
      3'b000:  return a + b + {15'd0, ci};
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return ~a;
      3'b101:  return a ^ b;
      3'b110:  return {a[14:0], ci};
      default: return {a[15], a[15:1]};
    endcase
  endfunction

  // Apply one operation, clock it, then compare the registered outputs.
  task automatic step(input string tag, input logic r_v, input logic [2:0] op,
                      input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic [15:0] exp_f);
    rst     = r_v;
    bus.opc = op;
    bus.n   = a;
    bus.m   = b;
    bus.c   = ci;
    @(posedge clk);
    #1;
    check(tag, {bus.f, bus.zer, bus.neg}, {exp_f, (exp_f == 16'h0000), exp_f[15]});
  endtask

  initial begin
    bus.n = '0; bus.m = '0; bus.opc = '0; bus.c = 1'b0;
    @(negedge clk);

    step("reset",      1'b1, 3'b101, 16'hA5A5, 16'h1234, 1'b1, 16'h0000);
    step("reset_hold", 1'b1, 3'b000, 16'd5,    16'd5,    1'b0, 16'h0000);

    step("add",  1'b0, 3'b000, 16'd8, 16'd3, 1'b0, 16'd11);
    step("sub",  1'b0, 3'b001, 16'd8, 16'd3, 1'b0, 16'd5);
    step("and",  1'b0, 3'b010, 16'd8, 16'd3, 1'b0, 16'd0);
    step("or",   1'b0, 3'b011, 16'd8, 16'd3, 1'b0, 16'd11);
    step("not",  1'b0, 3'b100, 16'd8, 16'd3, 1'b0, 16'hFFF7);
    step("xor",  1'b0, 3'b101, 16'd8, 16'd3, 1'b0, 16'd11);
    step("shl",  1'b0, 3'b110, 16'd8, 16'd3, 1'b0, 16'd16);
    step("asr",  1'b0, 3'b111, 16'd8, 16'd3, 1'b0, 16'd4);

    step("add_c1", 1'b0, 3'b000, 16'd8, 16'd3, 1'b1, 16'd12);
    step("sub_c1", 1'b0, 3'b001, 16'd8, 16'd3, 1'b1, 16'd5);
    step("shl_c1", 1'b0, 3'b110, 16'd8, 16'd3, 1'b1, 16'd17);
    step("not_m",  1'b0, 3'b100, 16'd8, 16'hFFFF, 1'b1, 16'hFFF7);

    step("add_ovf",  1'b0, 3'b000, 16'h7FFF, 16'h0001, 1'b0, 16'h8000);
    step("add_wrap", 1'b0, 3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
    step("sub_neg",  1'b0, 3'b001, 16'd3,    16'd8,    1'b0, 16'hFFFB);
    step("asr_neg",  1'b0, 3'b111, 16'h8002, 16'h0000, 1'b0, 16'hC001);
    step("add_cwrap",1'b0, 3'b000, 16'hFFFE, 16'h0001, 1'b1, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      logic [15:0] a, b;
      logic        ci, rv;
      logic [2:0]  op;
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      op = 3'(i);
      rv = (i == 6);
      step($sformatf("stream_%0d", i), rv, op, a, b, ci, rv ? 16'h0000 : ref_alu(op, a, b, ci));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu16_structural.md
Name: alu16_structural

Overview:
- 16-bit signed ALU with eight operations selected by a 3-bit opcode. Operand n, operand m and carry-in c feed the operation.
- Built from an internal combinational datapath: ripple adder/subtractor, bitwise logic slice, shifter and 8:1 result mux.
- Result and two status flags are registered on the clock. Sits as the execute stage of the datapath.

Parameters:
- WIDTH, 16, operand/result width; all rules below are stated for 16 and scale with WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- n  input  16  operand A, two's complement signed.
- m  input  16  operand B, two's complement signed.
- opc  input  3  operation select.
- c  input  1  carry-in; used by opc 000 and 110 only.
- f  output  16  registered result, signed.
- zer  output  1  registered zero flag.
- neg  output  1  registered negative flag.

Interface: one clock (clk); reset (rst) is synchronous and active-high.

Behaviour:
- Combinational result r is computed from the current n, m, opc and c.
- On each rising clk with rst=0:
  - f <= r
  - zer <= (r == 0)
  - neg <= r[15]
- Latency is one cycle: inputs applied before edge k appear on f, zer and neg after edge k. There is no handshake; a new operation is accepted every cycle.
- On a rising clk with rst=1: f <= 0, zer <= 1, neg <= 0. Reset has priority over any operation; a reset mid-stream discards the in-flight result.
- Before the first reset edge the outputs are undefined.
- Opcode map:
  - 000 ADD: r = n + m + c.
  - 001 SUB: r = n + ~m + 1 (n - m); c is ignored.
  - 010 AND: r = n & m.
  - 011 OR: r = n | m.
  - 100 NOT: r = ~n; m is ignored.
  - 101 XOR: r = n ^ m.
  - 110 SHL: r = {n[14:0], c}; c is shifted into the LSB.
  - 111 ASR: r = {n[15], n[15:1]}; arithmetic shift right by 1.
- Arithmetic wraps modulo 2^16. There is no carry-out or overflow output.
  - Example: 0x7FFF + 0x0001 gives 0x8000 with neg=1.
- zer and neg always describe the registered f, including for logic and shift operations.
- Unused operands never affect r.
- Adder/subtractor: a single ripple-carry chain of full adders shared by ADD and SUB. B-input inversion and carry-in are selected by opc.

Test Plan:
- Reset: assert rst for one edge with any inputs -> f=0x0000, zer=1, neg=0. Then hold rst=1 with opc=000, n=5, m=5 -> outputs stay at reset values.
- Sweep at n=8, m=3, c=0, one opcode per cycle, checking one cycle later:
  - ADD -> 11
  - SUB -> 5
  - AND -> 0 with zer=1
  - OR -> 11
  - NOT -> 0xFFF7 (-9) with neg=1
  - XOR -> 11
  - SHL -> 16
  - ASR -> 4
- Carry-in: n=8, m=3, c=1:
  - ADD -> 12
  - SUB -> 5 (c ignored)
  - SHL -> 17
- Wrap and flags:
  - ADD 0x7FFF + 0x0001, c=0 -> 0x8000, neg=1, zer=0.
  - ADD 0xFFFF + 0x0001 -> 0x0000, zer=1.
  - SUB n=3, m=8 -> 0xFFFB (-5), neg=1.
  - ASR n=0x8002 -> 0xC001.
- Latency and back-to-back: change opcode every cycle with random n, m, c for 7+ cycles -> each f equals the reference model of the previous cycle's inputs. Assert rst in the middle of the stream -> next f=0, zer=1; normal operation resumes on the following edge.
